// File: rtl/alu_control_seq_if.sv
// Control-FSM <-> ALU control bundle: decode inputs, multiply/divide operands and results.
interface alu_control_seq_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEL_W = 3
);
    logic [2:0]       ALUOp;
    logic [5:0]       Funct;
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SEL_W-1:0] Saida;
    logic             Break;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             DivZero;
    logic             Illegal;

    modport master (
        output ALUOp, Funct, Start, A, B,
        input  Saida, Break, Busy, Done, Hi, Lo, DivZero, Illegal
    );

    modport slave (
        input  ALUOp, Funct, Start, A, B,
        output Saida, Break, Busy, Done, Hi, Lo, DivZero, Illegal
    );
endinterface

// File: rtl/alu_control_seq.sv
// ALU selector/BREAK decode plus a radix-2 sequenced MULT/MULTU/DIV/DIVU engine with HI/LO.
// Divider datapath is built only when ALUCTL_DIV_EN is defined; otherwise DIV/DIVU report Illegal.
module alu_control_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEL_W = 3
) (
    input logic              Clk,
    input logic              Reset_n,
    alu_control_seq_if.slave bus
);
    localparam int unsigned     CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2*WIDTH:0] acc_q;
    logic [WIDTH-1:0] op_q, hi_q, lo_q;
    logic             sa_q, sb_q;
    logic             busy_q, done_q, div_zero_q, illegal_q;
    logic             pend_dz_q, pend_ill_q;
`ifdef ALUCTL_DIV_EN
    logic             is_div_q;
`endif

    // Combinational selector and BREAK decode
    logic [2:0] sel;
    always_comb begin
        sel = 3'b001;
        case (bus.ALUOp)
            3'b000: sel = 3'b001;
            3'b001: sel = 3'b010;
            3'b011: sel = 3'b011;
            3'b100: sel = 3'b111;
            3'b010: begin
                case (bus.Funct)
                    6'h20, 6'h21: sel = 3'b001;
                    6'h22, 6'h23: sel = 3'b010;
                    6'h24:        sel = 3'b011;
                    6'h26:        sel = 3'b110;
                    6'h2a:        sel = 3'b111;
                    default:      sel = 3'b000;
                endcase
            end
            default: sel = 3'b001;
        endcase
    end

    assign bus.Saida = SEL_W'(sel);
    assign bus.Break = (bus.ALUOp == 3'b010) && (bus.Funct == 6'h0d);

    // Funct 0x18..0x1b: bit1 selects divide, bit0 selects unsigned
    logic             is_md, f_div, f_signed, accept, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, op_init, acc_lo_init;
    assign is_md    = (bus.ALUOp == 3'b010) && (bus.Funct[5:2] == 4'b0110);
    assign f_div    = bus.Funct[1];
    assign f_signed = ~bus.Funct[0];
    assign accept   = bus.Start && is_md && (state_q != StRun);
    assign a_neg    = f_signed & bus.A[WIDTH-1];
    assign b_neg    = f_signed & bus.B[WIDTH-1];
    assign mag_a    = a_neg ? -bus.A : bus.A;
    assign mag_b    = b_neg ? -bus.B : bus.B;
`ifdef ALUCTL_DIV_EN
    assign op_init     = f_div ? mag_b : mag_a;
    assign acc_lo_init = f_div ? mag_a : mag_b;
`else
    assign op_init     = mag_a;
    assign acc_lo_init = mag_b;
`endif

    // One iteration of the engine plus the sign-corrected result of that iteration
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_next, step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;
`ifdef ALUCTL_DIV_EN
    logic [2*WIDTH:0]   shifted, div_next;
    logic [WIDTH:0]     trial;
`endif
    always_comb begin
        mul_sum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, op_q} : '0);
        mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        step     = mul_next;
        prod     = (sa_q ^ sb_q) ? -mul_next[2*WIDTH-1:0] : mul_next[2*WIDTH-1:0];
        res_hi   = prod[2*WIDTH-1:WIDTH];
        res_lo   = prod[WIDTH-1:0];
`ifdef ALUCTL_DIV_EN
        // Restoring division: remainder in the upper half, quotient shifts into the lower half
        shifted  = {acc_q[2*WIDTH-1:0], 1'b0};
        trial    = shifted[2*WIDTH:WIDTH] - {1'b0, op_q};
        div_next = trial[WIDTH] ? shifted : {trial, shifted[WIDTH-1:1], 1'b1};
        if (is_div_q) begin
            step   = div_next;
            res_lo = (sa_q ^ sb_q) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
            res_hi = sa_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
            pend_dz_q  <= 1'b0;
            pend_ill_q <= 1'b0;
`ifdef ALUCTL_DIV_EN
            is_div_q   <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
            case (state_q)
                StRun: begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= step;
                    if (cnt_q == LAST) begin
                        state_q    <= StDone;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        div_zero_q <= pend_dz_q;
                        illegal_q  <= pend_ill_q;
                        pend_dz_q  <= 1'b0;
                        pend_ill_q <= 1'b0;
                        if (!(pend_dz_q || pend_ill_q)) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    if (accept) begin
                        state_q <= StRun;
`ifdef ALUCTL_DIV_EN
                        is_div_q <= f_div;
                        if (f_div && (bus.B == '0)) begin
`else
                        if (f_div) begin
`endif
                            // Result-less completion: one quiet RUN cycle, then Done
                            cnt_q <= LAST;
`ifdef ALUCTL_DIV_EN
                            pend_dz_q  <= 1'b1;
`else
                            pend_ill_q <= 1'b1;
`endif
                        end else begin
                            busy_q <= 1'b1;
                            cnt_q  <= '0;
                            acc_q  <= {{(WIDTH + 1){1'b0}}, acc_lo_init};
                            op_q   <= op_init;
                            sa_q   <= a_neg;
                            sb_q   <= b_neg;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
    assign bus.DivZero = div_zero_q;
    assign bus.Illegal = illegal_q;
endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Parametrised successor to the combinational ALU control decoder. It keeps the single-cycle ALU selector and BREAK decode, and adds a sequenced radix-2 multiply/divide engine for MULT, MULTU, DIV and DIVU with a HI/LO result pair. It sits between the main control FSM and the datapath. The control FSM stalls on `Busy` and advances on `Done`.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `SEL_W`, 3: ALU selector width; must be at least 3.

Ports:
- `Clk`, input, 1: the single clock; all state is rising-edge.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `ALUOp`, input, 3: operation class from the control FSM.
- `Funct`, input, 6: instruction funct field.
- `Start`, input, 1: request to launch a multi-cycle op; sampled at the rising edge.
- `A`, input, `WIDTH`: rs operand, captured on accept.
- `B`, input, `WIDTH`: rt operand, captured on accept.
- `Saida`, output, `SEL_W`: combinational ALU selector.
- `Break`, output, 1: combinational; BREAK instruction decoded.
- `Busy`, output, 1: engine is running.
- `Done`, output, 1: one-cycle completion pulse.
- `Hi`, output, `WIDTH`: remainder, or upper half of the product.
- `Lo`, output, `WIDTH`: quotient, or lower half of the product.
- `DivZero`, output, 1: valid with `Done`; divisor was 0.
- `Illegal`, output, 1: valid with `Done`; the op is not compiled in.

## Operation
- `Saida` decode (zero-extended to `SEL_W`):
  - `ALUOp`=000 gives 001 (add).
  - `ALUOp`=001 gives 010 (sub).
  - `ALUOp`=011 gives 011 (and).
  - `ALUOp`=100 gives 111 (compare).
  - `ALUOp`=010 decodes `Funct`:
    - 0x20 and 0x21 give 001.
    - 0x22 and 0x23 give 010.
    - 0x24 gives 011.
    - 0x26 gives 110.
    - 0x2a gives 111.
    - Any other funct gives 000 (pass A).
  - Any other `ALUOp` gives 001.
- `Break` = (`ALUOp`==010) and (`Funct`==0x0d). BREAK is not asserted for non-R-type ops.
- Multi-cycle ops have `ALUOp`=010 and `Funct` in {0x18 MULT, 0x19 MULTU, 0x1a DIV, 0x1b DIVU}.
- FSM states are IDLE, RUN and DONE.
  - **IDLE/DONE:** an edge with `Start`=1 and a multi-cycle op captures A, B, the op and the signs, clears the counter and goes to RUN.
    - Exception: a divide with B==0 goes straight to DONE with `DivZero`=1.
    - `Start` with a non-multi-cycle op is ignored.
  - **RUN:** performs one shift-add or shift-subtract step per cycle. After `WIDTH` steps it goes to DONE.
  - **DONE:** lasts one cycle, then returns to IDLE unless a new op is accepted at that edge.
- `Start` while in RUN is ignored; the op is not queued.
- Signed ops run on magnitudes, then the signs are fixed:
  - The product is negated if the operand signs differ.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
- Signed overflow on divide: (−2^(WIDTH−1)) / (−1) gives LO=0x80000000 (wrapped) and HI=0.
- `Hi`/`Lo` update only at the edge entering DONE with a valid result. Otherwise they hold, including across a `DivZero` completion.
- The accumulator needs 2·`WIDTH`+1 bits internally. There is no overflow flag.

## Timing
- Reset values: `Busy`=0, `Done`=0, `Hi`=0, `Lo`=0, `DivZero`=0, `Illegal`=0, FSM in IDLE, counter 0.
- `Saida` and `Break` are combinational, with zero latency.
- Start accepted at edge k:
  - `Busy`=1 from edge k to edge k+`WIDTH`.
  - `Done`=1, and `Hi`/`Lo` are valid, from edge k+`WIDTH`, with `Busy`=0 in that cycle.
- Divide by zero accepted at edge k: `Done`=`DivZero`=1 from edge k+1. `Busy` stays 0.
- Back-to-back ops: a new `Start` is accepted during the DONE cycle, and `Busy` rises at that same edge.
- `DivZero` and `Illegal` are meaningful only while `Done`=1. Otherwise they are 0.
- `Reset_n` low mid-operation returns all state and outputs to their reset values immediately, without waiting for a clock edge. The in-flight op is discarded.

## Configuration
- `ALUCTL_DIV_EN` defined: DIV and DIVU run as specified above.
- `ALUCTL_DIV_EN` undefined:
  - The divider datapath is not synthesised; MULT and MULTU are unaffected.
  - An accepted DIV or DIVU goes directly to DONE and gives `Done`=`Illegal`=1 at edge k+1.
  - `Hi`/`Lo` are unchanged and `Busy` stays 0.

## Test plan
All scenarios use `WIDTH`=32.
1. Decode:
   - `ALUOp`=010, `Funct`=0x22 -> `Saida`=010.
   - `Funct`=0x2a -> `Saida`=111.
   - `Funct`=0x0d -> `Break`=1.
   - `ALUOp`=000, `Funct`=0x0d -> `Break`=0, `Saida`=001.
2. MULT A=0xFFFFFFFE, B=3, `Start` at edge k -> `Busy` for 32 cycles, `Done` at edge k+32, `Hi`=0xFFFFFFFF, `Lo`=0xFFFFFFFA.
3. MULTU A=B=0xFFFFFFFF -> `Hi`=0xFFFFFFFE, `Lo`=0x00000001. Then a second `Start` in the DONE cycle is accepted with no idle gap.
4. DIV A=0xFFFFFFF9 (−7), B=2 -> `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF. Then DIVU A=7, B=0 -> `Done`=`DivZero`=1 at k+1 with `Hi`/`Lo` unchanged.
5. `Reset_n` pulled low mid-clock at cycle 10 of a MULT -> `Busy`, `Done`, `Hi` and `Lo` go to 0 without an edge. A `Start` during RUN is ignored and `Done` pulses only once.
6. Build without `ALUCTL_DIV_EN`, run DIV A=10, B=3 -> `Done`=`Illegal`=1 at k+1, `Hi`/`Lo` unchanged. MULT still passes scenario 2.
